wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//   Arbitrates the single register-file write port between the pipeline WB stage and a
//   late-result path, such as a multi-cycle multiplier or slow memory return.
//   The WB stage has priority. Late results are queued in a small buffer and drained into
//   idle write slots.
//   Guarantees forward progress for late results. Reports pending destinations to the
//   hazard unit.
// PARAMETERS
//   DATA_W        32  write data width (`REGISTER_LEN)
//   ADDR_W         4  register address width (`REG_ADDRESS_LEN)
//   DEPTH          2  late-result buffer entries; power of 2, >=2
//   STARVE_LIMIT   4  consecutive lost slots before the buffer head is forced through
// PORTS
//   clk            in   1       clock; all state updates on rising edge
//   rst            in   1       asynchronous reset, active-low
//   pipe_wb_en     in   1       WB stage write request
//   pipe_wb_dest   in   ADDR_W  WB stage destination register
//   pipe_wb_value  in   DATA_W  WB stage write value
//   late_valid     in   1       late result offered
//   late_ready     out  1       buffer can accept a late result
//   late_dest      in   ADDR_W  late result destination
//   late_value     in   DATA_W  late result value
//   rf_we          out  1       register-file write enable
//   rf_waddr       out  ADDR_W  register-file write address
//   rf_wdata       out  DATA_W  register-file write data
//   pipe_stall     out  1       WB stage denied this cycle; pipeline must hold WB inputs
//   hz_src_addr    in   ADDR_W  hazard-unit query address
//   hz_pend_hit    out  1       a valid buffered entry targets hz_src_addr
//   pend_busy      out  1       buffer holds at least one valid entry
// BEHAVIOUR
//   - Reset (rst=0, async):
//     - Buffer emptied, all valid bits cleared, rd/wr pointers cleared, starve_cnt=0.
//     - While rst=0: rf_we=0, late_ready=0, pipe_stall=0, hz_pend_hit=0, pend_busy=0.
//   - Reset mid-operation discards buffered results. The late producer re-issues them.
//   - Late handshake: an entry is accepted on an edge where late_valid && late_ready.
//     - late_ready = (count != DEPTH), derived from registered count only.
//     - Full with a pop in the same cycle still gives late_ready=0 (no pass-through).
//   - Grant is combinational from current inputs and registered state.
//     - The register file commits on the same edge.
//     - force   = (starve_cnt == STARVE_LIMIT) && head_present
//     - pipe_go = pipe_wb_en && !force
//     - If pipe_go: rf_* = pipe_*.
//     - Else if head_present: pop the head.
//       - If the head is valid: rf_we=1, rf_* = head.
//       - If the head is squashed: rf_we=0, popped silently.
//     - Else rf_we=0.
//   - pipe_stall = pipe_wb_en && force. The same WB request is re-presented next cycle.
//   - Latency:
//     - Pipe write: 0 cycles (the edge on which it is presented).
//     - Late write: accepted at edge t, earliest commit at edge t+1.
//   - starve_cnt:
//     - Cleared when the buffer is empty or the head is popped.
//     - Otherwise increments when pipe_go and the buffer is non-empty; saturates at
//       STARVE_LIMIT.
//   - WAW ordering: buffered late results are always older than the WB stage instruction.
//     - On pipe_go with dest D, every buffered entry with dest D gets valid=0.
//     - A late result accepted on that same edge with dest D is stored with valid=0.
//   - hz_pend_hit: OR over entries of (valid && dest == hz_src_addr); combinational.
//   - pend_busy = OR of valid bits.
//   - Pointers are ADDR-free modulo-DEPTH counters with wrap. count = 0..DEPTH.
//     Simultaneous push and pop keeps count unchanged.
// STRUCTURE
//   - Defines.v: `REGISTER_LEN, `REG_ADDRESS_LEN (existing); add `WB_LATE_DEPTH and
//     `WB_STARVE_LIMIT.
//   - Sub-module wb_late_fifo holds the storage:
//     - Entry array {valid, dest, value} and pointers/count.
//     - Push/pop logic and the dest-match squash.
//     - hz compare.
//   - wb_port_arbiter holds grant logic, starve_cnt, the reset gating of outputs, and the
//     rf mux.
// TESTING
//   1. Reset mid-traffic:
//      - 2 entries buffered, rst=0 -> late_ready=0, rf_we=0, pend_busy=0 immediately.
//      - After release, count=0.
//   2. Idle drain:
//      - late {R5,0x1234} accepted at edge t, pipe idle.
//      - -> rf_we=1, rf_waddr=5, rf_wdata=0x1234 committed at edge t+1; pend_busy=0 after.
//   3. Full:
//      - Push 2 entries while pipe_wb_en=1 every cycle -> late_ready=0.
//      - A third late_valid is held, not accepted, until a pop frees a slot.
//   4. Starvation:
//      - pipe_wb_en=1 continuously with 1 buffered entry (R3).
//      - -> 4 pipe writes, then pipe_stall=1 for one cycle with rf_waddr=3.
//      - Held pipe write commits the next cycle.
//   5. WAW squash:
//      - Buffered {R7,0xAA} and pipe write {R7,0xBB}.
//      - -> rf writes 0xBB; entry popped later with rf_we=0; R7 ends as 0xBB.
//   6. Hazard query:
//      - Buffered R9 valid, hz_src_addr=9 -> hz_pend_hit=1.
//      - hz_src_addr=8 -> 0; after R9 drains -> 0.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared sizing constants for the register-file write-port arbiter and its late-result buffer.
package wb_port_arbiter_pkg;

    localparam int unsigned WB_DATA_W       = 32;
    localparam int unsigned WB_ADDR_W       = 4;
    localparam int unsigned WB_LATE_DEPTH   = 2;
    localparam int unsigned WB_STARVE_LIMIT = 4;

    // Pointer width for a power-of-two ring; never narrower than one bit.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/wb_late_fifo.sv
// Late-result ring buffer: {valid, dest, value} entries, WAW squash by destination and
// hazard-unit destination lookup.
module wb_late_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = WB_DATA_W,
    parameter int unsigned ADDR_W = WB_ADDR_W,
    parameter int unsigned DEPTH  = WB_LATE_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_dest,
    input  logic [DATA_W-1:0] push_value,
    input  logic              pop,
    input  logic              squash_en,
    input  logic [ADDR_W-1:0] squash_dest,
    input  logic [ADDR_W-1:0] hz_addr,
    output logic              full,
    output logic              head_present,
    output logic              head_valid,
    output logic [ADDR_W-1:0] head_dest,
    output logic [DATA_W-1:0] head_value,
    output logic              hz_hit,
    output logic              any_valid
);

    localparam int unsigned PTR_W = ptr_w(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  valid_q;
    logic [ADDR_W-1:0] dest_q  [DEPTH];
    logic [DATA_W-1:0] value_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              push_ok;
    logic              pop_ok;

    assign full         = (count_q == CNT_W'(DEPTH));
    assign head_present = (count_q != CNT_W'(0));
    assign push_ok      = push && !full;
    assign pop_ok       = pop && head_present;
    assign head_valid   = valid_q[rd_ptr_q];
    assign head_dest    = dest_q[rd_ptr_q];
    assign head_value   = value_q[rd_ptr_q];
    assign any_valid    = |valid_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push_ok && !pop_ok)      count_q <= count_q + CNT_W'(1);
            else if (!push_ok && pop_ok) count_q <= count_q - CNT_W'(1);
        end
    end

    // A newly pushed slot is never the popped slot: push needs !full, pop needs non-empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dest_q[i]  <= '0;
                value_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push_ok && (wr_ptr_q == PTR_W'(i))) begin
                    valid_q[i] <= !(squash_en && (push_dest == squash_dest));
                    dest_q[i]  <= push_dest;
                    value_q[i] <= push_value;
                end else if ((pop_ok && (rd_ptr_q == PTR_W'(i))) ||
                             (squash_en && (dest_q[i] == squash_dest))) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        hz_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (dest_q[i] == hz_addr)) hz_hit = 1'b1;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: WB stage has priority, buffered late results fill idle
// slots, and a starvation counter forces the buffer head through after repeated losses.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W       = WB_DATA_W,
    parameter int unsigned ADDR_W       = WB_ADDR_W,
    parameter int unsigned DEPTH        = WB_LATE_DEPTH,
    parameter int unsigned STARVE_LIMIT = WB_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_wb_en,
    input  logic [ADDR_W-1:0] pipe_wb_dest,
    input  logic [DATA_W-1:0] pipe_wb_value,
    input  logic              late_valid,
    output logic              late_ready,
    input  logic [ADDR_W-1:0] late_dest,
    input  logic [DATA_W-1:0] late_value,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              pipe_stall,
    input  logic [ADDR_W-1:0] hz_src_addr,
    output logic              hz_pend_hit,
    output logic              pend_busy
);

    localparam int unsigned SCNT_W = $clog2(STARVE_LIMIT + 1);

    logic [SCNT_W-1:0] starve_q;
    logic [SCNT_W-1:0] starve_d;
    logic              full;
    logic              head_present;
    logic              head_valid;
    logic [ADDR_W-1:0] head_dest;
    logic [DATA_W-1:0] head_value;
    logic              hz_hit;
    logic              any_valid;
    logic              force_head;
    logic              pipe_go;
    logic              pop;
    logic              push;

    assign force_head = (starve_q == SCNT_W'(STARVE_LIMIT)) && head_present;
    assign pipe_go    = pipe_wb_en && !force_head;
    assign pop        = !pipe_go && head_present;
    assign push       = late_valid && late_ready;

    wb_late_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .push_dest    (late_dest),
        .push_value   (late_value),
        .pop          (pop),
        .squash_en    (pipe_go),
        .squash_dest  (pipe_wb_dest),
        .hz_addr      (hz_src_addr),
        .full         (full),
        .head_present (head_present),
        .head_valid   (head_valid),
        .head_dest    (head_dest),
        .head_value   (head_value),
        .hz_hit       (hz_hit),
        .any_valid    (any_valid)
    );

    // Counts slots the head lost to the WB stage; any pop or an empty buffer restarts it.
    always_comb begin
        starve_d = starve_q;
        if (!head_present || pop) begin
            starve_d = '0;
        end else if (pipe_go && (starve_q != SCNT_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + SCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) starve_q <= '0;
        else      starve_q <= starve_d;
    end

    // Outputs are held quiet for the whole reset assertion, not just after the first edge.
    always_comb begin
        late_ready  = rst && !full;
        rf_we       = rst && (pipe_go || (pop && head_valid));
        rf_waddr    = pipe_go ? pipe_wb_dest  : head_dest;
        rf_wdata    = pipe_go ? pipe_wb_value : head_value;
        pipe_stall  = rst && pipe_wb_en && force_head;
        hz_pend_hit = rst && hz_hit;
        pend_busy   = rst && any_valid;
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: queue-based reference model, directed scenarios
// and a randomized traffic phase with pipeline-hold and valid/ready producer behaviour.
module tb_wb_port_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_wb_en;
    logic [3:0]  pipe_wb_dest;
    logic [31:0] pipe_wb_value;
    logic        late_valid;
    logic        late_ready;
    logic [3:0]  late_dest;
    logic [31:0] late_value;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        pipe_stall;
    logic [3:0]  hz_src_addr;
    logic        hz_pend_hit;
    logic        pend_busy;

    wb_port_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .pipe_wb_en    (pipe_wb_en),
        .pipe_wb_dest  (pipe_wb_dest),
        .pipe_wb_value (pipe_wb_value),
        .late_valid    (late_valid),
        .late_ready    (late_ready),
        .late_dest     (late_dest),
        .late_value    (late_value),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .pipe_stall    (pipe_stall),
        .hz_src_addr   (hz_src_addr),
        .hz_pend_hit   (hz_pend_hit),
        .pend_busy     (pend_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        logic [3:0]  d;
        logic [31:0] val;
    } ent_t;

    ent_t        q[$];
    int          starve;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] dut_rf [16];

    // Expected values for the current cycle, computed at the negedge.
    bit          e_ready, e_we, e_stall, e_hz, e_busy, go, pop, last_acc;
    logic [3:0]  e_addr;
    logic [31:0] e_data;
    bit          s_we;
    logic [3:0]  s_addr;
    logic [31:0] s_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        starve   = 0;
        last_acc = 1'b0;
        e_stall  = 1'b0;
    endtask

    task automatic drive(input bit pe, input logic [3:0] pd, input logic [31:0] pv,
                         input bit lv, input logic [3:0] ld, input logic [31:0] lval,
                         input logic [3:0] hz);
        pipe_wb_en = pe; pipe_wb_dest = pd; pipe_wb_value = pv;
        late_valid = lv; late_dest = ld; late_value = lval;
        hz_src_addr = hz;
    endtask

    // Compare DUT against the model away from the active edge.
    task automatic eval();
        bit head, frc;
        @(negedge clk);
        head    = (q.size() != 0);
        frc     = head && (starve == LIMIT);
        go      = pipe_wb_en && !frc;
        pop     = !go && head;
        e_ready = (q.size() != DEPTH);
        e_we    = go || (pop && q[0].v);
        e_addr  = go ? pipe_wb_dest : (head ? q[0].d : 4'd0);
        e_data  = go ? pipe_wb_value : (head ? q[0].val : 32'd0);
        e_stall = pipe_wb_en && frc;
        e_hz    = 1'b0;
        e_busy  = 1'b0;
        foreach (q[i]) if (q[i].v) begin
            e_busy = 1'b1;
            if (q[i].d == hz_src_addr) e_hz = 1'b1;
        end
        chk("late_ready", late_ready, e_ready);
        chk("rf_we", rf_we, e_we);
        chk("pipe_stall", pipe_stall, e_stall);
        chk("hz_pend_hit", hz_pend_hit, e_hz);
        chk("pend_busy", pend_busy, e_busy);
        if (e_we) begin
            chk("rf_waddr", rf_waddr, e_addr);
            chk("rf_wdata", rf_wdata, e_data);
        end
        s_we = rf_we; s_addr = rf_waddr; s_data = rf_wdata;
    endtask

    // Advance one edge and update the model from the specification's rules.
    task automatic tick();
        bit   acc, was_empty;
        ent_t e;
        @(posedge clk);
        acc       = late_valid && e_ready;
        was_empty = (q.size() == 0);
        if (s_we) dut_rf[s_addr] = s_data;
        if (go) foreach (q[i]) if (q[i].d == pipe_wb_dest) q[i].v = 1'b0;
        if (pop) q.delete(0);
        if (was_empty || pop) starve = 0;
        else if (go && starve < LIMIT) starve++;
        if (acc) begin
            e.v = !(go && (late_dest == pipe_wb_dest));
            e.d = late_dest;
            e.val = late_value;
            q.push_back(e);
        end
        last_acc = acc;
        #1;
    endtask

    task automatic drain();
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 20 && q.size() != 0; k++) begin
            eval(); tick();
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
        eval(); tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int nwr;
        int nwait;
        for (int i = 0; i < 16; i++) dut_rf[i] = '0;
        model_reset();
        rst = 1'b0;
        drive(1, 3, 32'h5, 1, 4, 32'h6, 4);
        repeat (2) @(posedge clk);
        #2;
        chk("rst_late_ready", late_ready, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_pipe_stall", pipe_stall, 0);
        chk("rst_pend_busy", pend_busy, 0);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        eval(); tick();

        // Idle drain: accepted at edge t, committed at t+1.
        drive(0, 0, 0, 1, 5, 32'h1234, 0);
        eval();
        chk("drain_ready", late_ready, 1);
        chk("drain_we0", rf_we, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        eval();
        chk("drain_we", rf_we, 1);
        chk("drain_addr", rf_waddr, 5);
        chk("drain_data", rf_wdata, 32'h1234);
        tick();
        eval();
        chk("drain_busy_after", pend_busy, 0);
        tick();

        // Full: third offer held until a forced pop frees a slot.
        drive(1, 1, 32'h10, 1, 10, 32'hA0, 0); eval(); tick();
        drive(1, 1, 32'h11, 1, 11, 32'hB0, 0); eval();
        chk("full_ready_before", late_ready, 1);
        tick();
        drive(1, 1, 32'h12, 1, 12, 32'hC0, 0);
        nwait = 0;
        for (int k = 0; k < 16; k++) begin
            eval();
            if (k == 0) chk("full_ready", late_ready, 0);
            tick();
            nwait++;
            if (last_acc) break;
        end
        chk("full_wait_cycles", nwait, 5);
        drain();

        // Starvation: four pipe writes then one forced head write, then the held WB write.
        drive(1, 1, 32'h50, 1, 3, 32'h33, 0); eval(); tick();
        drive(1, 2, 32'h100, 0, 0, 0, 0);
        nwr = 0;
        for (int k = 0; k < 10; k++) begin
            eval();
            if (pipe_stall) break;
            if (rf_we && rf_waddr == 4'd2) nwr++;
            tick();
        end
        chk("starve_pipe_writes", nwr, 4);
        chk("starve_stall", pipe_stall, 1);
        chk("starve_addr", rf_waddr, 3);
        chk("starve_data", rf_wdata, 32'h33);
        tick();
        eval();
        chk("starve_held_stall", pipe_stall, 0);
        chk("starve_held_addr", rf_waddr, 2);
        chk("starve_held_data", rf_wdata, 32'h100);
        tick();
        drain();

        // WAW squash: younger WB write to R7 kills the buffered one.
        drive(1, 1, 32'h11, 1, 7, 32'hAA, 0); eval(); tick();
        drive(1, 7, 32'hBB, 0, 0, 0, 0); eval();
        chk("waw_data", rf_wdata, 32'hBB);
        tick();
        drive(0, 0, 0, 0, 0, 0, 7); eval();
        chk("waw_pop_we", rf_we, 0);
        chk("waw_busy", pend_busy, 0);
        tick();
        chk("waw_r7", dut_rf[7], 32'hBB);
        drain();

        // Hazard query.
        drive(1, 1, 32'h1, 1, 9, 32'h99, 9); eval(); tick();
        drive(1, 2, 32'h2, 0, 0, 0, 9); eval();
        chk("hz_hit9", hz_pend_hit, 1);
        tick();
        drive(1, 2, 32'h2, 0, 0, 0, 8); eval();
        chk("hz_hit8", hz_pend_hit, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 9); eval(); tick();
        eval();
        chk("hz_after_drain", hz_pend_hit, 0);
        tick();

        // Reset mid-traffic with two entries buffered.
        drive(1, 1, 32'h1, 1, 4, 32'h44, 0); eval(); tick();
        drive(1, 2, 32'h2, 1, 5, 32'h55, 4); eval(); tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", late_ready, 0);
        chk("mid_rst_we", rf_we, 0);
        chk("mid_rst_busy", pend_busy, 0);
        chk("mid_rst_hz", hz_pend_hit, 0);
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 4);
        eval();
        chk("post_rst_ready", late_ready, 1);
        chk("post_rst_we", rf_we, 0);
        tick();

        // Randomized traffic: WB inputs held while stalled, late offers held until accepted.
        for (int c = 0; c < 3000; c++) begin
            if (!e_stall) begin
                pipe_wb_en    = ($urandom_range(0, 99) < 60);
                pipe_wb_dest  = 4'($urandom_range(0, 7));
                pipe_wb_value = $urandom;
            end
            if (!(late_valid && !last_acc)) begin
                late_valid = ($urandom_range(0, 99) < 45);
                late_dest  = 4'($urandom_range(0, 7));
                late_value = $urandom;
            end
            hz_src_addr = 4'($urandom_range(0, 7));
            eval();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
